// File: rtl/msg_feeder.sv
// Byte feeder between a host message stream and a hash core: buffers host bytes
// in a small FIFO, frames each message with start / End_Of_File and counts bytes delivered.
//   state    | meaning
//   IDLE     | no message open, waiting for first host transfer
//   START    | one-cycle start pulse to core, msg_len restarts
//   STREAM   | delivering FIFO bytes to core
//   EOF_WAIT | all bytes delivered, waiting for H_ready from core
module msg_feeder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic        in_empty,
  output logic        in_ready,
  output logic [7:0]  M,
  output logic        F_dr,
  input  logic        F_rtr,
  output logic        start,
  output logic        End_Of_File,
  input  logic        H_ready,
  output logic [31:0] msg_len,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, STREAM, EOF_WAIT} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          last_seen;
  logic          accept, marker, push, pop;

  // Ready is taken from registered count only, so a full FIFO never gets pop credit.
  assign in_ready = (state != EOF_WAIT) && !last_seen && (count < CNT_FULL);
  assign accept   = in_valid && in_ready;
  assign marker   = (state == IDLE) && in_empty;
  assign push     = accept && !marker;
  assign F_dr     = ((state == START) || (state == STREAM)) && (count != '0);
  assign pop      = F_dr && F_rtr;
  assign M        = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = START;
      START:    state_nxt = STREAM;
      STREAM:   if (last_seen && (count == '0)) state_nxt = EOF_WAIT;
      EOF_WAIT: if (H_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start       = 1'b0;
    End_Of_File = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE:     busy = 1'b0;
      START:    start = 1'b1;
      EOF_WAIT: End_Of_File = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            last_seen <= 1'b0;
    else if (state == EOF_WAIT && H_ready) last_seen <= 1'b0;
    else if (accept && (in_last || marker)) last_seen <= 1'b1;
  end

  // A byte can already be popped in the START cycle, so the restart value includes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       msg_len <= '0;
    else if (state == START)          msg_len <= pop ? 32'd1 : 32'd0;
    else if (pop && (msg_len != '1))  msg_len <= msg_len + 32'd1;
  end

endmodule

// File: tb/tb_msg_feeder.sv
// Bench for msg_feeder: directed vector table, hand-built corner sequences and
// random messages checked by a byte-queue scoreboard.
module tb_msg_feeder;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0, in_last = 1'b0, in_empty = 1'b0;
  logic        in_ready;
  logic [7:0]  M;
  logic        F_dr;
  logic        F_rtr = 1'b0;
  logic        start, End_Of_File;
  logic        H_ready = 1'b0;
  logic [31:0] msg_len;
  logic        busy;

  msg_feeder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_empty(in_empty), .in_ready(in_ready), .M(M),
    .F_dr(F_dr), .F_rtr(F_rtr), .start(start), .End_Of_File(End_Of_File),
    .H_ready(H_ready), .msg_len(msg_len), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [7:0] d; logic l; logic e; logic r; logic h;
    logic ir; logic fdr; logic [7:0] m; logic st; logic eof; logic bsy; logic [31:0] len;
  } vec_t;

  vec_t       tbl[12];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  bit         sb_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l,
                       input logic e, input logic r, input logic h);
    in_valid = v; in_data = d; in_last = l; in_empty = e; F_rtr = r; H_ready = h;
  endtask

  // Mid-cycle sampling; every byte handed to the core must be the oldest accepted one.
  task automatic sample(output logic acc);
    logic [7:0] want;
    @(negedge clk);
    acc = in_valid & in_ready;
    if (sb_on && F_dr && F_rtr) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL deliver: got byte 0x%0h, want no byte pending", M);
      end else begin
        want = exp_q.pop_front();
        chk("deliver", {24'd0, M}, {24'd0, want});
      end
    end
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic l, input logic e,
                     input logic r, input logic h, output logic acc);
    drive(v, d, l, e, r, h);
    sample(acc);
    adv();
  endtask

  task automatic finish_msg(input int len, input bit rnd);
    bit   eof_seen = 0;
    bit   done = 0;
    logic acc, h, r;
    for (int c = 0; c < 300 && !done; c++) begin
      h = rnd ? ($urandom_range(0, 3) == 0) : End_Of_File;
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      drive(1'b0, 8'h00, 1'b0, 1'b0, r, h);
      sample(acc);
      if (End_Of_File && !eof_seen) begin
        eof_seen = 1;
        chk("eof_msg_len", msg_len, 32'(len));
        chk("eof_all_delivered", 32'(exp_q.size()), 32'd0);
        chk("eof_in_ready", {31'd0, in_ready}, 32'd0);
      end
      if (eof_seen && !busy) begin
        done = 1;
        chk("idle_eof_low", {31'd0, End_Of_File}, 32'd0);
        chk("idle_len_hold", msg_len, 32'(len));
      end
      adv();
    end
    chk("msg_completed", {31'd0, done}, 32'd1);
  endtask

  task automatic send_msg(input int len, input bit rnd);
    logic [7:0] b[$];
    logic       acc, v, r, h, e;
    int         sent = 0;
    for (int i = 0; i < len; i++) b.push_back(8'($urandom_range(0, 255)));
    if (len == 0) begin
      for (int g = 0; g < 50 && sent == 0; g++) begin
        cyc(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b1, 1'b0, acc);
        if (acc) sent = 1;
      end
      chk("marker_accepted", 32'(sent), 32'd1);
    end else begin
      for (int g = 0; g < 400 && sent < len; g++) begin
        v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        h = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
        e = (sent > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        cyc(v, b[sent], (sent == len - 1), e, r, h, acc);
        if (acc) begin
          exp_q.push_back(b[sent]);
          sent++;
        end
      end
      chk("bytes_accepted", 32'(sent), 32'(len));
    end
    finish_msg(len, rnd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       acc;
    logic [7:0] msg[10];
    int         idx;

    //          v  d      l  e  r  h   ir fdr m     st eof bsy len
    tbl[0]  = '{1, 8'h61, 0, 0, 1, 0,  1, 0, 8'h00, 0, 0, 0, 0};
    tbl[1]  = '{1, 8'h62, 0, 0, 1, 0,  1, 1, 8'h61, 1, 0, 1, 0};
    tbl[2]  = '{1, 8'h63, 1, 0, 1, 0,  1, 1, 8'h62, 0, 0, 1, 1};
    tbl[3]  = '{0, 8'h00, 0, 0, 1, 0,  0, 1, 8'h63, 0, 0, 1, 2};
    tbl[4]  = '{0, 8'h00, 0, 0, 1, 0,  0, 0, 8'h00, 0, 0, 1, 3};
    tbl[5]  = '{0, 8'h00, 0, 0, 1, 1,  0, 0, 8'h00, 0, 1, 1, 3};
    tbl[6]  = '{0, 8'h00, 0, 0, 1, 0,  1, 0, 8'h00, 0, 0, 0, 3};
    tbl[7]  = '{1, 8'h5A, 0, 1, 1, 0,  1, 0, 8'h00, 0, 0, 0, 3};
    tbl[8]  = '{0, 8'h00, 0, 0, 1, 0,  0, 0, 8'h00, 1, 0, 1, 3};
    tbl[9]  = '{0, 8'h00, 0, 0, 1, 0,  0, 0, 8'h00, 0, 0, 1, 0};
    tbl[10] = '{0, 8'h00, 0, 0, 1, 1,  0, 0, 8'h00, 0, 1, 1, 0};
    tbl[11] = '{0, 8'h00, 0, 0, 1, 0,  1, 0, 8'h00, 0, 0, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_f_dr", {31'd0, F_dr}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_eof", {31'd0, End_Of_File}, 32'd0);
    chk("rst_msg_len", msg_len, 32'd0);
    rst_n = 1'b1;
    drive(0, 8'h00, 0, 0, 0, 0);
    sample(acc);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    adv();

    // 3-byte message followed by a zero-length message
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].e, tbl[i].r, tbl[i].h);
      sample(acc);
      chk($sformatf("tbl%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].ir});
      chk($sformatf("tbl%0d_f_dr", i), {31'd0, F_dr}, {31'd0, tbl[i].fdr});
      if (tbl[i].fdr) chk($sformatf("tbl%0d_M", i), {24'd0, M}, {24'd0, tbl[i].m});
      chk($sformatf("tbl%0d_start", i), {31'd0, start}, {31'd0, tbl[i].st});
      chk($sformatf("tbl%0d_eof", i), {31'd0, End_Of_File}, {31'd0, tbl[i].eof});
      chk($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].bsy});
      chk($sformatf("tbl%0d_msg_len", i), msg_len, tbl[i].len);
      adv();
    end

    sb_on = 1;
    exp_q.delete();

    // 10-byte message against a stalled core, then full-FIFO pop with no same-cycle credit
    for (int i = 0; i < 10; i++) msg[i] = 8'(8'h10 + i);
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(1'b1, msg[idx], (idx == 9), 1'b0, 1'b0, 1'b0, acc);
      if (acc) begin exp_q.push_back(msg[idx]); idx++; end
    end
    chk("stall_accepted", 32'(idx), 32'(DEPTH));
    chk("stall_f_dr", {31'd0, F_dr}, 32'd1);
    drive(1'b1, msg[idx], 1'b0, 1'b0, 1'b1, 1'b0);
    sample(acc);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_f_dr", {31'd0, F_dr}, 32'd1);
    chk("full_head", {24'd0, M}, 32'h10);
    adv();
    drive(1'b1, msg[idx], 1'b0, 1'b0, 1'b1, 1'b0);
    sample(acc);
    chk("after_pop_in_ready", {31'd0, in_ready}, 32'd1);
    if (acc) begin exp_q.push_back(msg[idx]); idx++; end
    adv();
    for (int g = 0; g < 50 && idx < 10; g++) begin
      cyc(1'b1, msg[idx], (idx == 9), 1'b0, 1'b1, 1'b0, acc);
      if (acc) begin exp_q.push_back(msg[idx]); idx++; end
    end
    chk("ten_accepted", 32'(idx), 32'd10);
    finish_msg(10, 0);

    // H_ready while streaming must be ignored
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'(8'hA0 + i), (i == 2), 1'b0, 1'b0, 1'b0, acc);
      chk("hr_accept", {31'd0, acc}, 32'd1);
      if (acc) exp_q.push_back(8'(8'hA0 + i));
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    sample(acc);
    chk("hr_ignored_busy", {31'd0, busy}, 32'd1);
    chk("hr_ignored_eof", {31'd0, End_Of_File}, 32'd0);
    chk("hr_ignored_f_dr", {31'd0, F_dr}, 32'd1);
    adv();
    finish_msg(3, 0);

    // Reset mid-stream with two bytes queued
    cyc(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0, 1'b0, acc); if (acc) exp_q.push_back(8'hC1);
    cyc(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0, 1'b0, acc); if (acc) exp_q.push_back(8'hC2);
    cyc(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, acc); if (acc) exp_q.push_back(8'hC3);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    chk("pre_rst_len", msg_len, 32'd1);
    chk("pre_rst_f_dr", {31'd0, F_dr}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_f_dr", {31'd0, F_dr}, 32'd0);
    chk("mid_rst_start", {31'd0, start}, 32'd0);
    chk("mid_rst_eof", {31'd0, End_Of_File}, 32'd0);
    chk("mid_rst_len", msg_len, 32'd0);
    exp_q.delete();
    adv();
    rst_n = 1'b1;
    drive(0, 8'h00, 0, 0, 0, 0);
    sample(acc);
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rel_start", {31'd0, start}, 32'd0);
    chk("rel_eof", {31'd0, End_Of_File}, 32'd0);
    chk("rel_f_dr", {31'd0, F_dr}, 32'd0);
    adv();
    send_msg(2, 0);

    // Random messages, stalls and stray H_ready pulses
    for (int n = 0; n < 25; n++) send_msg($urandom_range(0, 12), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/msg_feeder.md
MSG_FEEDER -- requirements
Module: msg_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries in the input byte FIFO (power of two, >=2).
REQ-002 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_data  input  8  host message byte.
REQ-005 SHALL have port in_valid  input  1  host byte (or empty-message marker) valid.
REQ-006 SHALL have port in_last  input  1  qualifies in_data as final message byte.
REQ-007 SHALL have port in_empty  input  1  with in_valid in IDLE: zero-length message, no byte carried.
REQ-008 SHALL have port in_ready  output  1  feeder accepts host transfer this cycle.
REQ-009 SHALL have port M  output  8  byte presented to hash core (FIFO head).
REQ-010 SHALL have port F_dr  output  1  M valid toward core.
REQ-011 SHALL have port F_rtr  input  1  core ready to receive.
REQ-012 SHALL have port start  output  1  one-cycle pulse opening a new message to the core.
REQ-013 SHALL have port End_Of_File  output  1  level: all message bytes delivered to core.
REQ-014 SHALL have port H_ready  input  1  core pulse: digest complete.
REQ-015 SHALL have port msg_len  output  32  bytes delivered for current/last message.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement states IDLE, START, STREAM, EOF_WAIT.
REQ-018 SHALL accept a host transfer when in_valid & in_ready; in_ready = (state != EOF_WAIT) & ~last_seen & (FIFO count < DEPTH), count taken from registered state (no same-cycle pop credit).
REQ-019 SHALL write in_data into FIFO on every accepted transfer except an IDLE transfer with in_empty=1.
REQ-020 SHALL ignore in_empty outside IDLE (transfer treated as a data byte).
REQ-021 SHALL set last_seen on an accepted transfer with in_last=1 or an IDLE transfer with in_empty=1.
REQ-022 SHALL go IDLE -> START on any accepted transfer; START -> STREAM unconditionally next cycle.
REQ-023 SHALL assert start exactly during the START cycle; clear msg_len to 0 in that cycle.
REQ-024 SHALL drive F_dr = (state in START/STREAM) & FIFO not empty; M = FIFO head, don't-care when F_dr=0.
REQ-025 SHALL pop FIFO and increment msg_len when F_dr & F_rtr; msg_len saturates at 0xFFFFFFFF.
REQ-026 SHALL support simultaneous push and pop in one cycle with count unchanged and byte order preserved.
REQ-027 SHALL go STREAM -> EOF_WAIT when last_seen & FIFO empty at cycle start; End_Of_File = 1 only in EOF_WAIT.
REQ-028 SHALL go EOF_WAIT -> IDLE on H_ready, clearing last_seen; msg_len holds its value until next START.
REQ-029 SHALL ignore H_ready in IDLE, START and STREAM.
REQ-030 SHALL deliver each byte to the core exactly once, in host order, with no loss while F_rtr is low.

Reset
REQ-031 SHALL on rst_n low asynchronously force state IDLE, FIFO empty, last_seen=0, msg_len=0, start=0, F_dr=0, End_Of_File=0, busy=0; in_ready=1 from first cycle after release.
REQ-032 SHALL discard any in-flight message on reset mid-operation; no start/End_Of_File glitch on release.

Verification
REQ-033 SHALL pass: 3-byte message 0x61,0x62,0x63(last), F_rtr=1 -> start one pulse, M delivers 61,62,63 in order, End_Of_File rises next cycle after empty, msg_len=3.
REQ-034 SHALL pass: in_valid & in_empty in IDLE -> start pulse, F_dr never high, End_Of_File high 2 cycles later, msg_len=0; H_ready -> IDLE.
REQ-035 SHALL pass: 10-byte message with F_rtr=0 -> in_ready drops after DEPTH=4 bytes accepted, F_dr held, no byte lost; F_rtr=1 resumes, all 10 delivered, msg_len=10.
REQ-036 SHALL pass: FIFO full with F_rtr=1 and in_valid=1 -> in_ready=0 that cycle, pop occurs, next cycle in_ready=1.
REQ-037 SHALL pass: H_ready pulse during STREAM -> ignored, state stays STREAM; later H_ready in EOF_WAIT -> IDLE, busy=0.
REQ-038 SHALL pass: rst_n low mid-STREAM with 2 bytes queued -> all outputs at reset values immediately, next message starts clean with msg_len counting from 0.
